// File: rtl/pipe_ctrl_fwd.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_fwd
//  Description : In-order pipeline backbone that provides valid/allowin
//                handshake, payload load enables, kill, RAW stall and
//                one-hot bypass selects for the decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_fwd #(
   parameter int STAGES     = 4,
   parameter int TAG_W      = 5,
   parameter int LATE_STAGE = 3,
   parameter int BYPASS     = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_allowin,
   input  logic              in_we,
   input  logic [TAG_W-1:0]  in_tag,
   input  logic              in_late,
   input  logic [STAGES-1:0] ready_go,
   input  logic [STAGES-1:0] kill,
   input  logic              out_allowin,
   output logic              out_valid,
   output logic [STAGES-1:0] stage_valid,
   output logic [STAGES-1:0] stage_load,
   input  logic              src1_use,
   input  logic [TAG_W-1:0]  src1_tag,
   input  logic              src2_use,
   input  logic [TAG_W-1:0]  src2_tag,
   output logic              hazard_stall,
   output logic [STAGES-1:0] fwd1_sel,
   output logic [STAGES-1:0] fwd2_sel
);

   logic [STAGES-1:0]             r_valid;
   logic [STAGES-1:0]             r_we;
   logic [STAGES-1:0]             r_late;
   logic [STAGES-1:0][TAG_W-1:0]  r_tag;

   logic [STAGES-1:0]             w_ev;
   logic [STAGES-1:0]             w_rg;
   logic [STAGES-1:0]             w_to_next;
   logic [STAGES-1:0]             w_allowin;
   logic [STAGES-1:0]             w_up_valid;
   logic [STAGES-1:0]             w_up_we;
   logic [STAGES-1:0]             w_up_late;
   logic [STAGES-1:0][TAG_W-1:0]  w_up_tag;
   logic [STAGES-1:0]             w_valid_nxt;
   logic [STAGES-1:0]             w_early;
   logic [STAGES-1:0]             w_m1;
   logic [STAGES-1:0]             w_m2;
   logic [STAGES-1:0]             w_y1;
   logic [STAGES-1:0]             w_y2;
   logic                          w_act1;
   logic                          w_act2;
   logic                          w_st1;
   logic                          w_st2;

   assign w_ev = r_valid & ~kill;

   // Stage 0 is the consumer itself, so it never contributes a match
   generate
      for (genvar j = 0; j < STAGES; j++) begin : g_stage
         assign w_early[j] = (j < LATE_STAGE);
         if (j == 0) begin : g_id
            assign w_m1[j] = 1'b0;
            assign w_m2[j] = 1'b0;
         end else begin : g_older
            assign w_m1[j] = w_ev[j] & r_we[j] & (r_tag[j] == src1_tag);
            assign w_m2[j] = w_ev[j] & r_we[j] & (r_tag[j] == src2_tag);
         end
      end
   endgenerate

   // Lowest set bit = youngest producer
   assign w_y1 = w_m1 & (-w_m1);
   assign w_y2 = w_m2 & (-w_m2);

   assign w_act1 = src1_use & (src1_tag != '0) & w_ev[0];
   assign w_act2 = src2_use & (src2_tag != '0) & w_ev[0];

   assign w_st1 = w_act1 & (|w_m1) & ((BYPASS == 0) | (|(w_y1 & r_late & w_early)));
   assign w_st2 = w_act2 & (|w_m2) & ((BYPASS == 0) | (|(w_y2 & r_late & w_early)));

   assign hazard_stall = w_st1 | w_st2;
   assign fwd1_sel     = (w_act1 && !hazard_stall) ? w_y1 : '0;
   assign fwd2_sel     = (w_act2 && !hazard_stall) ? w_y2 : '0;

   assign w_rg      = {ready_go[STAGES-1:1], ready_go[0] & ~hazard_stall};
   assign w_to_next = w_ev & w_rg;

   // Backpressure ripples from the output back toward decode
   always_comb begin
      logic a;
      a         = out_allowin;
      w_allowin = '0;
      for (int i = STAGES - 1; i >= 0; i--) begin
         a            = ~w_ev[i] | (w_rg[i] & a);
         w_allowin[i] = a;
      end
   end

   assign w_up_valid  = {w_to_next[STAGES-2:0], in_valid};
   assign w_up_we     = {r_we[STAGES-2:0], in_we};
   assign w_up_late   = {r_late[STAGES-2:0], in_late};
   assign w_up_tag    = {r_tag[STAGES-2:0], in_tag};
   assign w_valid_nxt = (w_allowin & w_up_valid) | (~w_allowin & w_ev);

   assign stage_load  = w_allowin & w_up_valid;
   assign in_allowin  = w_allowin[0];
   assign out_valid   = w_to_next[STAGES-1];
   assign stage_valid = r_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= '0;
         r_we    <= '0;
         r_late  <= '0;
         r_tag   <= '0;
      end else begin
         r_valid <= w_valid_nxt;
         for (int i = 0; i < STAGES; i++) begin
            if (stage_load[i]) begin
               r_we[i]   <= w_up_we[i];
               r_late[i] <= w_up_late[i];
               r_tag[i]  <= w_up_tag[i];
            end
         end
      end
   end

endmodule
`default_nettype wire
